// File: rtl/com_pkg.sv
// Shared widths and capture-state encoding for the COM receive path.
package com_pkg;

    localparam int COM_DATA_WIDTH    = 8;
    localparam int COM_RX_DEPTH_LOG2 = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } cap_state_t;

endpackage : com_pkg

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with a registered head output.
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int                   DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  FULL_COUNT = DEPTH;
    localparam logic [DEPTH_LOG2:0]  CNT_ONE    = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [DEPTH_LOG2:0]   count_reg, count_next;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;
    logic                  pop_accept;
    logic                  push_accept;
    logic                  bypass;

    always_comb begin
        empty       = (count_reg == '0);
        full        = (count_reg == FULL_COUNT);
        pop_accept  = pop && !empty;
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
        push_accept = push && (!full || pop_accept);

        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop_accept) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({push_accept, pop_accept})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase

        // The new head is the byte being written this cycle; the array has not seen it yet.
        bypass = push_accept && (wr_ptr_reg == rd_ptr_next);
    end

    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rd_valid_reg <= (count_next != '0);
            // When the FIFO drains, the last head byte is left on rd_data.
            if (count_next != '0) begin
                rd_data_reg <= bypass ? push_data : mem[rd_ptr_next];
            end
        end
    end

    assign count    = count_reg;
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;

endmodule : sync_fifo

// File: rtl/com_rx_fifo.sv
// Receive buffer between serial_port and phy_mem_ctrl: capture handshake,
// rd_ack edge-triggered pops and a sticky overflow flag around sync_fifo.
module com_rx_fifo
    import com_pkg::*;
#(
    parameter int DEPTH_LOG2 = COM_RX_DEPTH_LOG2,
    parameter int DATA_WIDTH = COM_DATA_WIDTH
) (
    input  logic                  clk50M,
    input  logic                  rst,
    input  logic                  uart_req,
    input  logic [DATA_WIDTH-1:0] uart_data,
    output logic                  uart_ack,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ack,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    cap_state_t state_reg;
    logic       uart_ack_reg;
    logic       rd_ack_prev_reg;
    logic       overflow_reg;

    logic push_req;
    logic pop_req;
    logic drop;
    logic fifo_full;
    logic fifo_empty;

    always_comb begin
        push_req = (state_reg == IDLE) && uart_req;
        pop_req  = rd_ack && !rd_ack_prev_reg && !fifo_empty;
        // Bytes are acked even when dropped so serial_port never stalls.
        drop     = push_req && fifo_full && !pop_req;
    end

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk50M),
        .srst      (rst),
        .push      (push_req),
        .push_data (uart_data),
        .pop       (pop_req),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count),
        .rd_data   (rd_data),
        .rd_valid  (rd_ready)
    );

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_reg    <= IDLE;
            uart_ack_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (uart_req) begin
                        uart_ack_reg <= 1'b1;
                        state_reg    <= WAIT_LOW;
                    end else begin
                        uart_ack_reg <= 1'b0;
                    end
                end
                WAIT_LOW: begin
                    uart_ack_reg <= 1'b0;
                    if (!uart_req) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    uart_ack_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            rd_ack_prev_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            rd_ack_prev_reg <= rd_ack;
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign uart_ack = uart_ack_reg;
    assign overflow = overflow_reg;

endmodule : com_rx_fifo

// File: tb/tb_com_rx_fifo.sv
// Self-checking bench for com_rx_fifo: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_com_rx_fifo;

    logic       clk50M = 1'b0;
    logic       rst = 1'b1;
    logic       uart_req = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       uart_ack;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_ack = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    com_rx_fifo dut (
        .clk50M       (clk50M),
        .rst          (rst),
        .uart_req     (uart_req),
        .uart_data    (uart_data),
        .uart_ack     (uart_ack),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_ack       (rd_ack),
        .count        (count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #10 clk50M = ~clk50M;

    // Reference model: a byte queue plus "may capture" and edge-memory flags.
    byte unsigned mq[$];
    bit           m_armed, m_ack, m_prev, m_ovf;
    logic [7:0]   m_last;

    typedef struct {
        logic       req;
        logic [7:0] data;
        logic       ack;
        logic       clr;
        logic       e_ack;
        logic       e_rdy;
        logic [7:0] e_data;
        logic [4:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_armed = 1'b1;
        m_ack   = 1'b0;
        m_prev  = 1'b0;
        m_ovf   = 1'b0;
        m_last  = 8'h00;
    endtask

    task automatic model_step(input bit req, input byte unsigned d, input bit ack, input bit clr);
        bit pop;
        bit push;
        bit dropped;
        pop     = ack && !m_prev && (mq.size() > 0);
        push    = req && m_armed;
        dropped = 1'b0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < 16) mq.push_back(d);
            else dropped = 1'b1;
        end
        m_ack   = push;
        m_armed = push ? 1'b0 : (!req ? 1'b1 : m_armed);
        m_ovf   = dropped ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_prev  = ack;
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic check_model();
        chk("model_uart_ack", uart_ack, m_ack);
        chk("model_rd_ready", rd_ready, mq.size() > 0);
        chk("model_rd_data", rd_data, m_last);
        chk("model_count", count, mq.size());
        chk("model_overflow", overflow, m_ovf);
    endtask

    task automatic cycle(input bit req, input logic [7:0] d, input bit ack, input bit clr);
        uart_req     = req;
        uart_data    = d;
        rd_ack       = ack;
        overflow_clr = clr;
        @(posedge clk50M);
        model_step(req, d, ack, clr);
        #1;
        check_model();
    endtask

    task automatic do_reset(input bit req);
        rst          = 1'b1;
        uart_req     = req;
        rd_ack       = 1'b0;
        overflow_clr = 1'b0;
        @(posedge clk50M);
        model_reset();
        #1;
        rst = 1'b0;
        check_model();
    endtask

    task automatic push_byte(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
        cycle(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    function automatic void add(input logic req, input logic [7:0] d, input logic ack, input logic clr,
                                input logic e_ack, input logic e_rdy, input logic [7:0] e_data,
                                input logic [4:0] e_cnt, input logic e_ovf);
        vec_t v;
        v.req = req; v.data = d; v.ack = ack; v.clr = clr;
        v.e_ack = e_ack; v.e_rdy = e_rdy; v.e_data = e_data; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
        tbl.push_back(v);
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: single capture with long request, empty pop, held rd_ack.
        add(1, 8'h41, 0, 0,  1, 1, 8'h41, 1, 0);
        for (int i = 0; i < 9; i++) add(1, 8'h41, 0, 0,  0, 1, 8'h41, 1, 0);
        add(0, 8'h00, 0, 0,  0, 1, 8'h41, 1, 0);
        add(0, 8'h00, 1, 0,  0, 0, 8'h41, 0, 0);
        add(0, 8'h00, 0, 0,  0, 0, 8'h41, 0, 0);
        add(0, 8'h00, 1, 0,  0, 0, 8'h41, 0, 0);
        add(0, 8'h00, 0, 0,  0, 0, 8'h41, 0, 0);
        add(1, 8'h10, 0, 0,  1, 1, 8'h10, 1, 0);
        add(0, 8'h00, 0, 0,  0, 1, 8'h10, 1, 0);
        add(1, 8'h11, 0, 0,  1, 1, 8'h10, 2, 0);
        add(0, 8'h00, 0, 0,  0, 1, 8'h10, 2, 0);
        add(1, 8'h12, 0, 0,  1, 1, 8'h10, 3, 0);
        add(0, 8'h00, 0, 0,  0, 1, 8'h10, 3, 0);
        for (int i = 0; i < 5; i++) add(0, 8'h00, 1, 0,  0, 1, 8'h11, 2, 0);
        add(0, 8'h00, 0, 0,  0, 1, 8'h11, 2, 0);
        add(0, 8'h00, 0, 1,  0, 1, 8'h11, 2, 0);

        do_reset(1'b0);
        chk("reset_count", count, 0);
        chk("reset_rd_ready", rd_ready, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_uart_ack", uart_ack, 0);
        chk("reset_overflow", overflow, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].req, tbl[i].data, tbl[i].ack, tbl[i].clr);
            chk($sformatf("tbl%0d_uart_ack", i), uart_ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d_rd_ready", i), rd_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].e_data);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].e_ovf);
        end

        // Overflow: 16 bytes then a dropped 0xAA; clear, then drop+clear together.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("full_count", count, 16);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("drop_ack", uart_ack, 1);
        chk("drop_overflow", overflow, 1);
        chk("drop_count", count, 16);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_overflow", overflow, 0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b1);
        chk("set_wins_overflow", overflow, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_order%0d", i), rd_data, i);
            pop_one();
        end
        chk("drain_count", count, 0);
        chk("drain_rd_ready", rd_ready, 0);
        chk("drain_rd_data_held", rd_data, 8'h0F);

        // Full with same-cycle pop edge and push: accepted, no overflow.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("fullpp_count", count, 16);
        chk("fullpp_overflow", overflow, 0);
        chk("fullpp_ack", uart_ack, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("fullpp_order%0d", k), rd_data, (k < 15) ? (8'h21 + k) : 8'h55);
            pop_one();
        end
        chk("fullpp_empty", rd_ready, 0);

        // 20 bytes through one slot across pointer wrap, with push and pop together.
        do_reset(1'b0);
        push_byte(8'h80);
        for (int i = 1; i < 20; i++) begin
            cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            chk($sformatf("wrap_data%0d", i), rd_data, 8'h80 + i);
            chk($sformatf("wrap_count%0d", i), count, 1);
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
        end
        pop_one();
        chk("wrap_final_count", count, 0);
        chk("wrap_final_ready", rd_ready, 0);

        // Reset mid-operation with request still high.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) push_byte(8'(8'h60 + i));
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        chk("pre_rst_count", count, 7);
        do_reset(1'b1);
        chk("midrst_count", count, 0);
        chk("midrst_ready", rd_ready, 0);
        chk("midrst_overflow", overflow, 0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        chk("post_rst_ack", uart_ack, 1);
        chk("post_rst_count", count, 1);
        chk("post_rst_data", rd_data, 8'h77);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h78, 1'b0, 1'b0);
            chk($sformatf("post_rst_noack%0d", i), uart_ack, 0);
        end
        chk("post_rst_single", count, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic: fill-biased phase, then drain-biased phase.
        do_reset(1'b0);
        for (int i = 0; i < 700; i++) begin
            bit r_req, r_ack, r_clr;
            r_req = ($urandom_range(0, 1) == 1);
            r_ack = (i < 350) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
            r_clr = ($urandom_range(0, 15) == 0);
            cycle(r_req, 8'($urandom), r_ack, r_clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_com_rx_fifo

// File: doc/com_rx_fifo.md
Name: com_rx_fifo

Overview:
- Receive-side buffer between serial_port (upstream producer: int_req/data_out/int_ack) and phy_mem_ctrl (downstream consumer: com_read_ready/com_data_in/int_com_ack).
- Absorbs bursts of received bytes while the CPU is busy, so serial_port's single-byte holding register is never overwritten.
- Reports a sticky overflow flag and the current fill level for a status register.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- DATA_WIDTH, 8, byte width.

Ports:
- clk50M  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- uart_req  in  1  serial_port int_req; level, held high until acknowledged.
- uart_data  in  DATA_WIDTH  serial_port data_out; valid while uart_req is high.
- uart_ack  out  1  to serial_port int_ack; one-cycle pulse.
- rd_ready  out  1  to phy_mem_ctrl com_read_ready; FIFO not empty.
- rd_data  out  DATA_WIDTH  to phy_mem_ctrl com_data_in; head byte.
- rd_ack  in  1  from phy_mem_ctrl int_com_ack; level, may be held for several cycles.
- count  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- overflow  out  1  sticky: a byte was dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Clock and reset: one clock, clk50M. Reset is synchronous and active-high (rst).
- Reset values:
  - uart_ack=0, rd_ready=0, rd_data=0, count=0, overflow=0.
  - Read and write pointers = 0; capture FSM = IDLE; rd_ack edge register = 0.
  - Reset mid-operation discards all contents immediately. It does not wait for uart_req to drop.
- Capture FSM (upstream side):
  - IDLE: on uart_req=1, latch uart_data and assert a push request this cycle. Register uart_ack=1 for the next cycle only, then go to WAIT_LOW.
  - WAIT_LOW: hold uart_ack=0. Return to IDLE when uart_req=0. A byte is captured at most once per uart_req high period.
  - Full and no pop in the same cycle: the byte is discarded, uart_ack is still pulsed, and overflow is set to 1. The byte is acked rather than stalled so serial_port never blocks.
- Pop (downstream side):
  - A pop occurs on the rising edge of rd_ack (rd_ack=1 with the registered previous value =0) while count>0.
  - Pop while empty is ignored and does not underflow.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When full, a same-cycle pop frees the slot, so the push is accepted and no overflow is raised.
  - When empty with a push in the same cycle, no pop occurs, since the byte is not yet visible.
- Latency:
  - A byte captured in cycle N is visible at cycle N+1: rd_ready=1 and rd_data equals that byte.
  - After a pop in cycle N, rd_data shows the next entry at N+1. If the FIFO is now empty, rd_ready=0 at N+1 and rd_data holds its last value.
  - Read mode is first-word fall-through.
- Pointers and count:
  - Pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2.
  - count is DEPTH_LOG2+1 bits. full = (count==2^DEPTH_LOG2); empty = (count==0).
- Overflow:
  - Set by a dropped byte; cleared by overflow_clr.
  - If overflow_clr and a drop occur in the same cycle, set wins.
- Outputs: all outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- com_pkg holds:
  - COM_DATA_WIDTH=8 and COM_RX_DEPTH_LOG2=4.
  - Capture FSM state encodings: IDLE=1'b0, WAIT_LOW=1'b1.
- One sub-module, sync_fifo: storage array, pointers and count, with push/pop/full/empty, first-word fall-through.
- com_rx_fifo adds the capture FSM, the rd_ack edge detector and the overflow logic.

Test Plan:
- Reset, then one byte 0x41 with uart_req held high for 10 cycles → exactly one uart_ack pulse, 1 cycle after capture; rd_ready=1 and rd_data=0x41 the cycle after capture; count=1.
- Push 0x00..0x0F without popping, then one more byte 0xAA → count=16, uart_ack still pulsed for 0xAA, overflow=1; subsequent pops return 0x00..0x0F in order and never 0xAA.
- rd_ack held high for 5 cycles with 3 entries 0x10,0x11,0x12 → exactly one pop; count=2, rd_data=0x11.
- FIFO full (16 entries); push 0x55 in the same cycle as an rd_ack rising edge → count stays 16, overflow=0, and 0x55 is read as the 16th byte after the first pop.
- Push 20 bytes and pop 20 bytes interleaved across pointer wrap → data order preserved, count returns to 0, rd_ready=0.
- rst asserted with count=7 and the FSM in WAIT_LOW → next cycle count=0, rd_ready=0, overflow=0. With uart_req still high after reset, one new capture and ack occur.
